alu_exec_core: RTL and testbench

ALU_EXEC_CORE -- requirements
Module: alu_exec_core

---
 rtl/alu_exec_core_pkg.sv | 35 +++
 rtl/alu_exec_core_input_mux.sv | 53 +++++
 rtl/alu_exec_core.sv | 104 ++++++++++
 tb/tb_alu_exec_core.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_exec_core_pkg.sv
// Shared encodings for the ALU execute stage: operation codes, operand
// source selects and flag bit positions.
package alu_exec_core_pkg;

    // alu_operation_select values
    localparam logic OP_ARITH = 1'b0;
    localparam logic OP_LOGIC = 1'b1;

    // Arithmetic group (alu_operation_select = 0)
    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_MUL  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    // Logic group (alu_operation_select = 1)
    localparam logic [1:0] ALU_AND  = 2'b00;
    localparam logic [1:0] ALU_OR   = 2'b01;
    localparam logic [1:0] ALU_XOR  = 2'b10;
    localparam logic [1:0] ALU_SHL  = 2'b11;

    // Operand source selects; every code from SEL_ZERO upward yields zero
    localparam logic [4:0] SEL_IDEX_OWN  = 5'd0;
    localparam logic [4:0] SEL_EXMEM_TOP = 5'd1;
    localparam logic [4:0] SEL_EXMEM_BOT = 5'd2;
    localparam logic [4:0] SEL_MEMWB_TOP = 5'd3;
    localparam logic [4:0] SEL_MEMWB_BOT = 5'd4;
    localparam logic [4:0] SEL_IDEX_OPP  = 5'd5;
    localparam logic [4:0] SEL_ZERO      = 5'd6;

    // Flag vector bit positions
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

endpackage

// File: rtl/alu_exec_core_input_mux.sv
// Two-lane forwarding mux. Lane 0 is the top operand, lane 1 the bottom;
// both lanes decode the same select encoding, differing only in which
// ID/EX operand counts as "own" and which as "opposite".
import alu_exec_core_pkg::*;

module alu_input_mux #(
    parameter int DATA_W = 8
) (
    input  logic [4:0]        top_sel,
    input  logic [4:0]        bot_sel,
    input  logic [DATA_W-1:0] idex_top,
    input  logic [DATA_W-1:0] idex_bot,
    input  logic [DATA_W-1:0] exmem_top,
    input  logic [DATA_W-1:0] exmem_bot,
    input  logic [DATA_W-1:0] memwb_top,
    input  logic [DATA_W-1:0] memwb_bot,
    output logic [DATA_W-1:0] top_op,
    output logic [DATA_W-1:0] bot_op
);

    logic [1:0][4:0]        sel;
    logic [1:0][DATA_W-1:0] own;
    logic [1:0][DATA_W-1:0] opp;
    logic [1:0][DATA_W-1:0] res;

    assign sel = {bot_sel, top_sel};
    assign own = {idex_bot, idex_top};
    assign opp = {idex_top, idex_bot};

    for (genvar g = 0; g < 2; g++) begin : g_lane
        logic [DATA_W-1:0] lane_res;

        // Per-lane source decode; unused codes fall through to zero
        always_comb begin
            lane_res = '0;
            case (sel[g])
                SEL_IDEX_OWN:  lane_res = own[g];
                SEL_EXMEM_TOP: lane_res = exmem_top;
                SEL_EXMEM_BOT: lane_res = exmem_bot;
                SEL_MEMWB_TOP: lane_res = memwb_top;
                SEL_MEMWB_BOT: lane_res = memwb_bot;
                SEL_IDEX_OPP:  lane_res = opp[g];
                default:       lane_res = '0;
            endcase
        end

        assign res[g] = lane_res;
    end

    assign top_op = res[0];
    assign bot_op = res[1];

endmodule

// File: rtl/alu_exec_core.sv
// ALU execute stage: operand forwarding, optional top inversion, 8-bit
// arithmetic/logic ALU with a full-width multiply, combinational flags and
// a one-cycle registered copy of those flags.
import alu_exec_core_pkg::*;

module alu_exec_core #(
    parameter int DATA_W = 8
) (
    input  logic                  clock,
    input  logic                  nreset,
    input  logic [4:0]            alu_top_sel,
    input  logic [4:0]            alu_bot_sel,
    input  logic [DATA_W-1:0]     data_in_top,
    input  logic [DATA_W-1:0]     data_in_bot,
    input  logic [DATA_W-1:0]     ex_mem_data_top,
    input  logic [DATA_W-1:0]     ex_mem_data_bot,
    input  logic [DATA_W-1:0]     mem_wb_data_top,
    input  logic [DATA_W-1:0]     mem_wb_data_bot,
    input  logic                  invert_top,
    input  logic                  alu_operation_select,
    input  logic [1:0]            alu_operation,
    output logic [2*DATA_W-1:0]   alu_out,
    output logic [2:0]            flags_out,
    output logic [2:0]            cur_flags
);

    logic [DATA_W-1:0]   top_sel_op;
    logic [DATA_W-1:0]   t_op;
    logic [DATA_W-1:0]   b_op;
    logic [DATA_W:0]     sum_w;
    logic [DATA_W:0]     diff_w;
    logic [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0]   res;
    logic                carry;
    logic                is_mul;

    alu_input_mux #(.DATA_W(DATA_W)) u_mux (
        .top_sel   (alu_top_sel),
        .bot_sel   (alu_bot_sel),
        .idex_top  (data_in_top),
        .idex_bot  (data_in_bot),
        .exmem_top (ex_mem_data_top),
        .exmem_bot (ex_mem_data_bot),
        .memwb_top (mem_wb_data_top),
        .memwb_bot (mem_wb_data_bot),
        .top_op    (top_sel_op),
        .bot_op    (b_op)
    );

    assign t_op = top_sel_op ^ {DATA_W{invert_top}};

    // Shared arithmetic; diff_w[DATA_W] is the borrow (B < T unsigned)
    assign sum_w  = {1'b0, b_op} + {1'b0, t_op};
    assign diff_w = {1'b0, b_op} - {1'b0, t_op};
    assign prod   = {{DATA_W{1'b0}}, b_op} * {{DATA_W{1'b0}}, t_op};
    assign is_mul = (alu_operation_select == OP_ARITH) && (alu_operation == ALU_MUL);

    // Low-byte result and carry for every operation
    always_comb begin
        res   = '0;
        carry = 1'b0;
        if (alu_operation_select == OP_ARITH) begin
            case (alu_operation)
                ALU_ADD:  {carry, res} = sum_w;
                ALU_SUB:  {carry, res} = diff_w;
                ALU_MUL: begin
                    res   = prod[DATA_W-1:0];
                    carry = |prod[2*DATA_W-1:DATA_W];
                end
                ALU_PASS: res = t_op;
                default:  res = '0;
            endcase
        end else begin
            case (alu_operation)
                ALU_AND: res = b_op & t_op;
                ALU_OR:  res = b_op | t_op;
                ALU_XOR: res = b_op ^ t_op;
                ALU_SHL: begin
                    res   = {t_op[DATA_W-2:0], 1'b0};
                    carry = t_op[DATA_W-1];
                end
                default: res = '0;
            endcase
        end
    end

    // MUL exposes the full product; everything else packs carry above the byte
    assign alu_out = is_mul ? prod : {{(DATA_W-1){1'b0}}, carry, res};

    // Flags: Z over the whole output, N from the top bit of the active width
    always_comb begin
        flags_out         = '0;
        flags_out[FLAG_Z] = (alu_out == '0);
        flags_out[FLAG_C] = carry;
        flags_out[FLAG_N] = is_mul ? alu_out[2*DATA_W-1] : alu_out[DATA_W-1];
    end

    // Registered flags, loaded every edge, cleared asynchronously
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) cur_flags <= '0;
        else         cur_flags <= flags_out;
    end

endmodule

// File: tb/tb_alu_exec_core.sv
// Self-checking bench for alu_exec_core: directed scenarios, a forwarding
// sweep, reset behaviour and randomized traffic against an arithmetic model.
module tb_alu_exec_core;

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic [4:0]  alu_top_sel = '0, alu_bot_sel = '0;
    logic [7:0]  data_in_top = '0, data_in_bot = '0;
    logic [7:0]  ex_mem_data_top = '0, ex_mem_data_bot = '0;
    logic [7:0]  mem_wb_data_top = '0, mem_wb_data_bot = '0;
    logic        invert_top = 1'b0, alu_operation_select = 1'b0;
    logic [1:0]  alu_operation = '0;
    logic [15:0] alu_out;
    logic [2:0]  flags_out, cur_flags;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    logic [2:0] exp_cur = '0;

    alu_exec_core #(.DATA_W(8)) dut (
        .clock(clock), .nreset(nreset),
        .alu_top_sel(alu_top_sel), .alu_bot_sel(alu_bot_sel),
        .data_in_top(data_in_top), .data_in_bot(data_in_bot),
        .ex_mem_data_top(ex_mem_data_top), .ex_mem_data_bot(ex_mem_data_bot),
        .mem_wb_data_top(mem_wb_data_top), .mem_wb_data_bot(mem_wb_data_bot),
        .invert_top(invert_top), .alu_operation_select(alu_operation_select),
        .alu_operation(alu_operation),
        .alu_out(alu_out), .flags_out(flags_out), .cur_flags(cur_flags)
    );

    always #5 clock = ~clock;

    // Source value picked by a select, from one lane's point of view
    function automatic int pick(input int sel, input int own, input int opp);
        case (sel)
            0: return own;
            1: return int'(ex_mem_data_top);
            2: return int'(ex_mem_data_bot);
            3: return int'(mem_wb_data_top);
            4: return int'(mem_wb_data_bot);
            5: return opp;
            default: return 0;
        endcase
    endfunction

    // Reference: returns {alu_out[15:0], N, C, Z} for the current inputs
    function automatic logic [18:0] model();
        int t, b, o, c, n;
        bit mul;
        t = pick(int'(alu_top_sel), int'(data_in_top), int'(data_in_bot));
        b = pick(int'(alu_bot_sel), int'(data_in_bot), int'(data_in_top));
        if (invert_top) t = 255 - t;
        c = 0;
        mul = 1'b0;
        if (!alu_operation_select) begin
            case (alu_operation)
                2'd0: begin o = b + t; c = (o > 255) ? 1 : 0; end
                2'd1: begin c = (b < t) ? 1 : 0; o = (b - t + 256) % 256 + 256 * c; end
                2'd2: begin o = b * t; c = (o > 255) ? 1 : 0; mul = 1'b1; end
                default: o = t;
            endcase
        end else begin
            case (alu_operation)
                2'd0: o = b & t;
                2'd1: o = b | t;
                2'd2: o = b ^ t;
                default: begin c = t / 128; o = (t * 2) % 256 + 256 * c; end
            endcase
        end
        n = mul ? (o / 32768) % 2 : (o / 128) % 2;
        return {o[15:0], n[0], c[0], (o == 0)};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [4:0] ts, input logic [4:0] bs, input logic [7:0] t,
                         input logic [7:0] b, input logic inv, input logic ls, input logic [1:0] op);
        @(posedge clock); #1;
        alu_top_sel = ts; alu_bot_sel = bs; data_in_top = t; data_in_bot = b;
        invert_top = inv; alu_operation_select = ls; alu_operation = op;
    endtask

    // Expected registered flags: cleared by reset, else last edge's model flags
    always @(posedge clock or negedge nreset) begin
        if (!nreset) exp_cur <= 3'b000;
        else         exp_cur <= model() & 19'h7;
    end

    // Continuous compare on the falling edge, away from input changes
    always @(negedge clock) begin
        logic [18:0] m;
        if (chk_en) begin
            m = model();
            check("alu_out", int'(alu_out), int'(m[18:3]));
            check("flags_out", int'(flags_out), int'(m[2:0]));
            check("cur_flags", int'(cur_flags), int'(exp_cur));
        end
    end

    initial begin
        logic [18:0] m;
        logic [7:0] fwd_exp [6];
        logic [4:0] fwd_sel [6];

        // Reset state
        #3;
        check("reset_cur_flags", int'(cur_flags), 0);
        @(posedge clock); #2;
        nreset = 1'b1;
        chk_en = 1'b1;

        // ADD 0xF1 + 0x0F
        apply(5'd0, 5'd0, 8'h0F, 8'hF1, 1'b0, 1'b0, 2'b00);
        #1; m = model();
        check("add_model", int'(m), int'({16'h0100, 3'b010}));
        @(negedge clock); #1;
        check("add_out", int'(alu_out), 16'h0100);
        check("add_flags", int'(flags_out), 3'b010);
        @(posedge clock); #1;
        check("add_cur_flags", int'(cur_flags), 3'b010);

        // SUB 5 - 7
        apply(5'd0, 5'd0, 8'h07, 8'h05, 1'b0, 1'b0, 2'b01);
        #1; m = model();
        check("sub_model", int'(m), int'({16'h01FE, 3'b110}));
        @(negedge clock); #1;
        check("sub_out", int'(alu_out), 16'h01FE);
        check("sub_flags", int'(flags_out), 3'b110);

        // XOR equal operands
        apply(5'd0, 5'd0, 8'hA5, 8'hA5, 1'b0, 1'b1, 2'b10);
        #1; m = model();
        check("xor_model", int'(m), int'({16'h0000, 3'b001}));
        @(negedge clock); #1;
        check("xor_out", int'(alu_out), 0);
        check("xor_flags", int'(flags_out), 3'b001);

        // PASS of inverted zero
        apply(5'd0, 5'd0, 8'h00, 8'h33, 1'b1, 1'b0, 2'b11);
        #1; m = model();
        check("pass_model", int'(m), int'({16'h00FF, 3'b100}));
        @(negedge clock); #1;
        check("pass_out", int'(alu_out), 16'h00FF);
        check("pass_flags", int'(flags_out), 3'b100);

        // SHL of 0x81: result 0x02, carry out the top bit
        apply(5'd0, 5'd0, 8'h81, 8'h00, 1'b0, 1'b1, 2'b11);
        @(negedge clock); #1;
        check("shl_out", int'(alu_out), 16'h0102);

        // Forwarding sweep on the top lane via PASS
        ex_mem_data_top = 8'h33; ex_mem_data_bot = 8'h44;
        mem_wb_data_top = 8'h55; mem_wb_data_bot = 8'h66;
        fwd_sel = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd7};
        fwd_exp = '{8'h33, 8'h44, 8'h55, 8'h66, 8'h22, 8'h00};
        for (int i = 0; i < 6; i++) begin
            apply(fwd_sel[i], 5'd0, 8'h11, 8'h22, 1'b0, 1'b0, 2'b11);
            @(negedge clock); #1;
            check($sformatf("fwd_sel%0d", fwd_sel[i]), int'(alu_out), int'(fwd_exp[i]));
        end

        // MUL 0xFF * 0xFF, then reset mid-cycle with nonzero cur_flags
        apply(5'd0, 5'd0, 8'hFF, 8'hFF, 1'b0, 1'b0, 2'b10);
        #1; m = model();
        check("mul_model", int'(m), int'({16'hFE01, 3'b110}));
        @(negedge clock); #1;
        check("mul_out", int'(alu_out), 16'hFE01);
        check("mul_flags", int'(flags_out), 3'b110);
        @(posedge clock); #1;
        check("mul_cur_flags", int'(cur_flags), 3'b110);
        #1; nreset = 1'b0;
        #1;
        check("async_reset_cur_flags", int'(cur_flags), 0);
        check("reset_comb_out", int'(alu_out), 16'hFE01);
        @(negedge clock); #2;
        nreset = 1'b1;
        @(posedge clock); #1;
        check("post_reset_load", int'(cur_flags), 3'b110);

        // Randomized traffic, checked by the negedge compare process
        for (int i = 0; i < 400; i++) begin
            @(posedge clock); #1;
            alu_top_sel = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            alu_bot_sel = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            data_in_top = 8'($urandom); data_in_bot = 8'($urandom);
            ex_mem_data_top = 8'($urandom); ex_mem_data_bot = 8'($urandom);
            mem_wb_data_top = 8'($urandom); mem_wb_data_bot = 8'($urandom);
            invert_top = 1'($urandom); alu_operation_select = 1'($urandom);
            alu_operation = 2'($urandom);
        end
        @(negedge clock); #1;
        chk_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
